// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock qualification and core reset release sequencer
// Optional macro PLL_RETRY_EN: a WAIT_LOCK timeout re-pulses pll_rst instead of waiting on.
module pll_reset_seq #(
   parameter int RST_PULSE_CYCLES   = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int TIMEOUT_CYCLES     = 65536
) (
   input  logic       clk_74a,
   input  logic       reset_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       core_reset_n,
   output logic       pll_ready,
   output logic [7:0] relock_count,
   output logic [7:0] timeout_count
);
   typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

   localparam logic [7:0]  RST_LAST    = 8'(RST_PULSE_CYCLES - 1);
   localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [19:0] TMO_LAST    = 20'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [1:0]  sync_q;
   logic [7:0]  rst_cnt_q;
   logic [15:0] stable_cnt_q;
   logic [19:0] tmo_cnt_q;
   logic        pll_rst_q;
   logic        core_reset_n_q;
   logic        pll_ready_q;
   logic [7:0]  relock_q;
   logic [7:0]  timeout_q;
   logic [7:0]  relock_d;
   logic [7:0]  timeout_d;
   logic        lk;

   assign lk        = sync_q[1];
   assign relock_d  = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
   assign timeout_d = (timeout_q == 8'hFF) ? timeout_q : timeout_q + 8'd1;

   always_ff @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= RESET_PLL;
         sync_q         <= 2'b00;
         rst_cnt_q      <= 8'd0;
         stable_cnt_q   <= 16'd0;
         tmo_cnt_q      <= 20'd0;
         pll_rst_q      <= 1'b1;
         core_reset_n_q <= 1'b0;
         pll_ready_q    <= 1'b0;
         relock_q       <= 8'd0;
         timeout_q      <= 8'd0;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
         case (state_q)
            RESET_PLL: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_q   <= WAIT_LOCK;
                  pll_rst_q <= 1'b0;
                  tmo_cnt_q <= 20'd0;
               end else begin
                  rst_cnt_q <= rst_cnt_q + 8'd1;
               end
            end
            WAIT_LOCK: begin
               if (lk) begin
                  state_q      <= STABLE;
                  stable_cnt_q <= 16'd0;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  timeout_q <= timeout_d;
`ifdef PLL_RETRY_EN
                  state_q   <= RESET_PLL;
                  pll_rst_q <= 1'b1;
                  rst_cnt_q <= 8'd0;
`else
                  tmo_cnt_q <= 20'd0;
`endif
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 20'd1;
               end
            end
            STABLE: begin
               // A loss sample wins over a counter completing in the same cycle.
               if (!lk) begin
                  state_q   <= WAIT_LOCK;
                  tmo_cnt_q <= 20'd0;
               end else if (stable_cnt_q == STABLE_LAST) begin
                  state_q        <= RUN;
                  core_reset_n_q <= 1'b1;
                  pll_ready_q    <= 1'b1;
               end else begin
                  stable_cnt_q <= stable_cnt_q + 16'd1;
               end
            end
            RUN: begin
               if (!lk) begin
                  state_q        <= RESET_PLL;
                  pll_rst_q      <= 1'b1;
                  core_reset_n_q <= 1'b0;
                  pll_ready_q    <= 1'b0;
                  rst_cnt_q      <= 8'd0;
                  relock_q       <= relock_d;
               end
            end
            default: state_q <= RESET_PLL;
         endcase
      end
   end

   assign pll_rst       = pll_rst_q;
   assign core_reset_n  = core_reset_n_q;
   assign pll_ready     = pll_ready_q;
   assign relock_count  = relock_q;
   assign timeout_count = timeout_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - scoreboard bench for pll_reset_seq (RST 4, STABLE 8, TIMEOUT 32)
module tb_pll_reset_seq;
   logic       clk_74a    = 1'b0;
   logic       reset_n    = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       core_reset_n;
   logic       pll_ready;
   logic [7:0] relock_count;
   logic [7:0] timeout_count;

   int   total = 0;
   int   bad   = 0;
   int   cyc;
   event chk_now;

   typedef struct {
      int         cyc;
      bit         imm;
      logic       rst;
      logic       crn;
      logic       rdy;
      logic [7:0] rl;
      logic [7:0] tm;
   } exp_t;

   exp_t  q[$];
   string nq[$];

   pll_reset_seq #(
      .RST_PULSE_CYCLES  (4),
      .LOCK_STABLE_CYCLES(8),
      .TIMEOUT_CYCLES    (32)
   ) dut (
      .clk_74a      (clk_74a),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .pll_rst      (pll_rst),
      .core_reset_n (core_reset_n),
      .pll_ready    (pll_ready),
      .relock_count (relock_count),
      .timeout_count(timeout_count)
   );

   always #5 clk_74a = ~clk_74a;

   // Cycle index: value seen at a falling edge is the cycle number since reset release.
   always @(posedge clk_74a or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic expect_at(input int c, input bit imm, input logic r, input logic crn,
                            input logic rdy, input logic [7:0] rl, input logic [7:0] tm,
                            input string n);
      exp_t e;
      e.cyc = c; e.imm = imm; e.rst = r; e.crn = crn; e.rdy = rdy; e.rl = rl; e.tm = tm;
      q.push_back(e);
      nq.push_back(n);
   endtask

   task automatic wait_cyc(input int n);
      int g = 0;
      while (cyc != n && g < 20000) begin
         @(negedge clk_74a);
         g++;
      end
      if (cyc != n) begin
         total++;
         bad++;
         $display("FAIL wait_cyc: cycle %0d never reached, now %0d", n, cyc);
      end
   endtask

   initial begin : monitor
      exp_t  e;
      string n;
      forever begin
         @(negedge clk_74a or chk_now);
         while (q.size() > 0 && (q[0].imm || q[0].cyc <= cyc)) begin
            e = q.pop_front();
            n = nq.pop_front();
            total++;
            if (!e.imm && e.cyc < cyc) begin
               bad++;
               $display("FAIL %s: check for cycle %0d missed, now cycle %0d", n, e.cyc, cyc);
            end else if ({pll_rst, core_reset_n, pll_ready, relock_count, timeout_count} !==
                         {e.rst, e.crn, e.rdy, e.rl, e.tm}) begin
               bad++;
               $display("FAIL %s cyc=%0d: got rst=%b crn=%b rdy=%b relock=%0d tmo=%0d, want rst=%b crn=%b rdy=%b relock=%0d tmo=%0d",
                        n, cyc, pll_rst, core_reset_n, pll_ready, relock_count, timeout_count,
                        e.rst, e.crn, e.rdy, e.rl, e.tm);
            end
         end
      end
   end

   initial begin : stim
      int         d;
      logic [7:0] a;
      logic [7:0] b;

      @(posedge clk_74a); #1;
      expect_at(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "reset_hold");
      -> chk_now;

      // Power-up lock, then 300 lock losses in RUN.
      repeat (2) @(posedge clk_74a);
      #1 reset_n = 1'b1;
      expect_at(0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "pulse_c0");
      expect_at(3,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "pulse_c3");
      expect_at(4,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "pulse_end");
      expect_at(20, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "pre_run");
      expect_at(21, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, "run_entry");
      wait_cyc(10);
      pll_locked = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         d = 25 + 16 * (k - 1);
         a = (k > 255) ? 8'd255 : 8'(k);
         b = (k - 1 > 255) ? 8'd255 : 8'(k - 1);
         wait_cyc(d);
         expect_at(d + 2,  1'b0, 1'b0, 1'b1, 1'b1, b, 8'd0, "loss_pre");
         expect_at(d + 3,  1'b0, 1'b1, 1'b0, 1'b0, a, 8'd0, "loss_hit");
         expect_at(d + 6,  1'b0, 1'b1, 1'b0, 1'b0, a, 8'd0, "relock_pulse_last");
         expect_at(d + 7,  1'b0, 1'b0, 1'b0, 1'b0, a, 8'd0, "relock_pulse_done");
         expect_at(d + 16, 1'b0, 1'b0, 1'b1, 1'b1, a, 8'd0, "relock_run");
         pll_locked = 1'b0;
         wait_cyc(d + 3);
         pll_locked = 1'b1;
      end
      wait_cyc(4830);

      // Asynchronous reset from RUN, checked between clock edges.
      @(posedge clk_74a); #1;
      expect_at(0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 8'd0, "run_before_rst");
      -> chk_now;
      #1 reset_n = 1'b0;
      #1;
      expect_at(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "async_rst");
      -> chk_now;

      // One-cycle lock drop during STABLE.
      pll_locked = 1'b0;
      repeat (2) @(posedge clk_74a);
      #1 reset_n = 1'b1;
      expect_at(0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "p2_c0");
      expect_at(21, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "glitch_hold");
      expect_at(26, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "glitch_pre");
      expect_at(27, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, "glitch_run");
      wait_cyc(10);
      pll_locked = 1'b1;
      wait_cyc(15);
      pll_locked = 1'b0;
      wait_cyc(16);
      pll_locked = 1'b1;
      wait_cyc(30);

      // Lock never arrives: timeouts.
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      repeat (2) @(posedge clk_74a);
      #1 reset_n = 1'b1;
      expect_at(3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "tmo_pulse_c3");
      expect_at(4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "tmo_pulse_end");
      expect_at(35, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "tmo_pre1");
`ifdef PLL_RETRY_EN
      expect_at(36,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1,   "retry1");
      expect_at(39,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1,   "retry1_last");
      expect_at(40,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1,   "retry1_done");
      expect_at(71,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1,   "retry2_pre");
      expect_at(72,   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2,   "retry2");
      expect_at(9179, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd254, "retry_254");
      expect_at(9180, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, "retry_255");
      expect_at(9252, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd255, "retry_sat");
      wait_cyc(9260);
`else
      expect_at(36,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1,   "tmo1");
      expect_at(67,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1,   "tmo2_pre");
      expect_at(68,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd2,   "tmo2");
      expect_at(8163, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd254, "tmo_254");
      expect_at(8164, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, "tmo_255");
      expect_at(8260, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255, "tmo_sat");
      wait_cyc(8270);
`endif
      #1;
      if (q.size() != 0) begin
         total += q.size();
         bad   += q.size();
         $display("FAIL pending: %0d checks never reached, first %s", q.size(), nq[0]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: cycles pll_rst is held high per reset attempt (range 1..255).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before core release (range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: maximum WAIT_LOCK cycles before retry (range 1..2^20-1).
REQ-004 SHALL have port clk_74a, input, 1: the single clock, free-running reference clock.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pll_locked, input, 1: PLL lock status, asynchronous to clk_74a.
REQ-007 SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-008 SHALL have port core_reset_n, output, 1: active-low reset for logic clocked by PLL outputs.
REQ-009 SHALL have port pll_ready, output, 1: high only in state RUN.
REQ-010 SHALL have port relock_count, output, 8: count of lock-loss events seen in RUN, saturating.
REQ-011 SHALL have port timeout_count, output, 8: count of WAIT_LOCK timeouts, saturating.

Function
REQ-012 SHALL pass pll_locked through a 2-flop synchronizer; "lk" below denotes the second flop's output (2-cycle latency).
REQ-013 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN; all outputs registered.
REQ-014 RESET_PLL: pll_rst=1, core_reset_n=0; after exactly RST_PULSE_CYCLES cycles -> WAIT_LOCK with pll_rst=0.
REQ-015 WAIT_LOCK: lk=1 -> STABLE with stable counter cleared; timeout counter increments each cycle; counter reaching TIMEOUT_CYCLES with lk=0 -> timeout action per REQ-024/025.
REQ-016 STABLE: stable counter increments while lk=1; lk=0 on any cycle -> WAIT_LOCK with timeout counter cleared; counter reaching LOCK_STABLE_CYCLES -> RUN.
REQ-017 RUN: core_reset_n=1 and pll_ready=1 on the first RUN cycle; lk=0 -> RESET_PLL, core_reset_n=0 and pll_ready=0 on the next edge, relock_count +1.
REQ-018 relock_count and timeout_count SHALL saturate at 255, never wrap.
REQ-019 Lock glitches shorter than one clk_74a period MAY be missed; any lk=0 sample SHALL be acted upon per REQ-016/017.
REQ-020 lk=0 in the same cycle STABLE's counter completes SHALL take the WAIT_LOCK path (loss wins).

Reset
REQ-021 reset_n low SHALL asynchronously force: state RESET_PLL, pll_rst=1, core_reset_n=0, pll_ready=0, all counters and synchronizer flops 0.
REQ-022 On reset_n deassertion the RESET_PLL pulse SHALL start counting from cycle 0 (full RST_PULSE_CYCLES pulse).
REQ-023 Reset asserted mid-operation (any state) SHALL abort immediately with REQ-021 values; no counts preserved.

Configuration
REQ-024 With macro PLL_RETRY_EN defined: WAIT_LOCK timeout -> RESET_PLL (new pulse), timeout_count +1.
REQ-025 Without PLL_RETRY_EN: WAIT_LOCK timeout SHALL increment timeout_count once, restart the timeout counter, and remain in WAIT_LOCK (pll_rst stays 0); timeout_count still increments per timeout period.

Verification (params RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, TIMEOUT_CYCLES=32)
REQ-026 Release reset, raise pll_locked at cycle 10 and hold -> pll_rst high cycles 0-3, core_reset_n rises at cycle 10+2+8 (+/-1 per state-entry cycle, fixed by RTL and documented), relock_count=0.
REQ-027 In STABLE, drop pll_locked 1 cycle at 5th stable cycle -> returns WAIT_LOCK, core_reset_n stays 0, stable count restarts on re-lock.
REQ-028 In RUN, drop pll_locked -> core_reset_n=0 within 3 cycles, pll_rst pulses 4 cycles, relock_count=1; repeat 300 times -> relock_count=255.
REQ-029 pll_locked held 0: PLL_RETRY_EN defined -> pll_rst pulses every 4+32 cycles, timeout_count increments each; undefined -> single 4-cycle pulse, pll_rst stays 0, timeout_count increments every 32 cycles.
REQ-030 Assert reset_n low in RUN mid-cycle -> pll_rst=1, core_reset_n=0, counters 0 without waiting for a clock edge.
